sram_1w1r_param: RTL and testbench
==================================

# sram_1w1r_param

Parametrised single-clock, one-write/one-read SRAM model for FPGA builds. It is the next generation of the team's fixed 32-bit, 2K-word 1W1R memory and is generalised in width, depth and read latency. It adds a selectable read-during-write policy, a read-valid strobe and an optional clear-on-reset sweep. It sits between the accelerator datapath and the Wishbone-side loaders wherever an inferred block RAM stands in for the ASIC SRAM macro.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of 8
- ADDR_WIDTH, 11, address width
- RAM_DEPTH, 1<<ADDR_WIDTH, number of words (derived, not overridden)
- NUM_WMASKS, DATA_WIDTH/8, byte-lane count (derived)
- READ_LATENCY, 1, cycles from sampled read to dout1; legal values are 1 and 2
- RDW_MODE, 0, same-address read-during-write policy: 0 returns old data, 1 returns new data
- CLEAR_ON_RESET, 1, when set, zero every word after reset

Ports:
- clk  in  1  sole clock; every port is sampled on the rising edge
- rst  in  1  reset; synchronous, active-high
- csb0  in  1  write select, active low
- wmask0  in  NUM_WMASKS  byte write enables; bit i covers din0[8i+7:8i]
- addr0  in  ADDR_WIDTH  write address
- din0  in  DATA_WIDTH  write data
- csb1  in  1  read select, active low
- addr1  in  ADDR_WIDTH  read address
- dout1  out  DATA_WIDTH  read data; holds its value between reads
- dout1_valid  out  1  one-cycle pulse marking new dout1 data
- busy  out  1  memory is unavailable; requests made while busy is high are dropped

## Operation
- Write: on a rising edge with csb0=0 and busy=0, each byte lane i with wmask0[i]=1 is written. If wmask0=0, no change is made.
- Read: on a rising edge with csb1=0 and busy=0, mem[addr1] is launched into the read pipe. Back-to-back reads run at one per cycle.
- Read and write to different addresses in the same cycle are independent.
- Read-during-write to the same address in the same cycle:
  - RDW_MODE=0: dout1 carries the pre-write word.
  - RDW_MODE=1: dout1 carries a per-byte merge. Masked lanes take din0; unmasked lanes take the old word.
- Clear state machine, states S_CLEAR and S_IDLE:
  - While rst=1: state is S_CLEAR, the clear counter is 0, busy=1.
  - After rst falls with CLEAR_ON_RESET=1: one word per cycle is written to zero, from address 0 up to RAM_DEPTH-1. The FSM enters S_IDLE after the last word, and busy falls on the following edge.
  - With CLEAR_ON_RESET=0: the FSM goes S_CLEAR to S_IDLE on the first edge with rst=0. Memory contents are undefined in simulation (X).
- Requests while busy=1: writes are discarded. Reads produce no dout1_valid and do not change dout1.
- Reset mid-operation: in-flight reads are squashed (no valid pulse is emitted) and the sweep restarts at address 0. A write sampled on the same edge as rst=1 is discarded.
- Reset values: dout1=0, dout1_valid=0, busy=1.

## Timing
- A read sampled at edge N produces dout1 and dout1_valid=1 after:
  - edge N+1 when READ_LATENCY=1;
  - edge N+2 when READ_LATENCY=2, where the extra stage is a pure output register.
- A write sampled at edge N is visible to a read sampled at edge N+1.
- At edge N itself, the write is visible only when RDW_MODE=1.
- Clear duration with CLEAR_ON_RESET=1: counting from the first edge with rst=0, busy stays 1 for RAM_DEPTH edges. It reads 0 after edge RAM_DEPTH+1. The first accepted request is the one sampled at that edge.
- busy is registered, with no combinational path from rst to busy.
- There are no combinational paths from any input to any output.

## Structure
- Package sram_pkg holds:
  - localparams RDW_OLD=0 and RDW_NEW=1;
  - the state typedef sram_clr_state_t {S_CLEAR, S_IDLE};
  - a function computing NUM_WMASKS from DATA_WIDTH.
- Sub-module sram_clear_ctrl holds the FSM, the clear counter and busy. Its outputs are clr_we, clr_addr and busy. The top level muxes clr_we/clr_addr onto the write port.
- The memory array, byte-lane write, RDW merge and read pipe live in the top level. Elaboration fails on READ_LATENCY outside {1,2} or on DATA_WIDTH%8≠0.

## Test plan
- Clear sweep. Config: ADDR_WIDTH=4, CLEAR_ON_RESET=1. Stimulus: pulse rst for 3 cycles. Response: busy=1 for 16 edges after rst falls, then 0; a read of every address returns 0.
- Byte masks. Stimulus: write 0xAABBCCDD at address 5 with mask 4'b1111, then 0x11223344 with mask 4'b0101, then read address 5. Response: 0xAA22CC44.
- RDW policy. Stimulus: write 0xFFFFFFFF at address 7 with mask 4'b0011, and in the same cycle read address 7, which held 0x12345678. Response: RDW_MODE=0 gives 0x12345678; RDW_MODE=1 gives 0x1234FFFF.
- Latency and throughput. Stimulus: reads of addresses 0..3 on consecutive cycles. Response: dout1_valid high on 4 consecutive cycles, starting 1 edge after the first request (READ_LATENCY=1) or 2 edges after (READ_LATENCY=2). Data is in order.
- Reset mid-operation. Stimulus: assert rst in the middle of a read burst, while the clear sweep is at address 9, with a write pending. Response: no dout1_valid pulse after rst; dout1=0; the sweep restarts at address 0; the pending write is lost.
- Busy drop. Stimulus: during the sweep, write 0xDEADBEEF at address 2, then read it after busy=0. Response: 0x00000000.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised 1W1R SRAM model.
package sram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } sram_clr_state_t;

  function automatic int calc_num_wmasks(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/sram_1w1r_param_if.sv
// Write/read port bundle for sram_1w1r_param.
interface sram_1w1r_param_if
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
);
  localparam int NUM_WMASKS = calc_num_wmasks(DATA_WIDTH);

  // Handshake: a request is offered by driving its csb low for one rising edge.
  // There is no per-request ready; busy=1 is a blanket "not ready" and any
  // request sampled while the memory is unavailable is dropped, not stalled.
  // Read results come back as dout1 with a one-cycle dout1_valid pulse.
  logic                  csb0;
  logic [NUM_WMASKS-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic                  csb1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] dout1;
  logic                  dout1_valid;
  logic                  busy;

  modport master (
    output csb0, wmask0, addr0, din0, csb1, addr1,
    input  dout1, dout1_valid, busy
  );

  modport slave (
    input  csb0, wmask0, addr0, din0, csb1, addr1,
    output dout1, dout1_valid, busy
  );

endinterface

// File: rtl/sram_clear_ctrl.sv
// Post-reset clear sequencer: walks the array writing zeros, owns busy.
module sram_clear_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 11,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  busy,
  output sram_clr_state_t       state
);

  sram_clr_state_t       state_q;
  sram_clr_state_t       state_nx;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] cnt_nx;
  logic                  busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      // busy trails the FSM by one edge so it is a pure register output
      busy_q  <= (state_q != S_IDLE);
    end
  end

  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    clr_we   = 1'b0;
    case (state_q)
      S_CLEAR: begin
        if (CLEAR_ON_RESET != 0) begin
          clr_we = !rst;
          cnt_nx = cnt_q + 1'b1;
          if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
            state_nx = S_IDLE;
          end
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_IDLE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_CLEAR;
      end
    endcase
  end

  assign clr_addr = cnt_q;
  assign busy     = busy_q;
  assign state    = state_q;

endmodule

// File: rtl/sram_1w1r_param.sv
// Parametrised single-clock 1W1R SRAM with byte masks, RDW policy, read pipe
// and optional post-reset clear sweep.
module sram_1w1r_param
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 11,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_MODE       = RDW_OLD,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_1w1r_param_if.slave      bus,
  output sram_clr_state_t       dbg_state,
  output logic [ADDR_WIDTH-1:0] dbg_clr_addr
);

  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
  localparam int NUM_WMASKS = calc_num_wmasks(DATA_WIDTH);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("sram_1w1r_param: READ_LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("sram_1w1r_param: DATA_WIDTH must be a multiple of 8");
  end

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  busy;
  sram_clr_state_t       clr_state;

  sram_clear_ctrl #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .busy     (busy),
    .state    (clr_state)
  );

  // Requests are honoured once the sweep has finished; the edge on which
  // busy drops is already an accepting edge.
  logic open_q;
  logic wr_req;
  logic rd_req;
  assign open_q = (clr_state == S_IDLE) && !rst;
  assign wr_req = !bus.csb0 && open_q;
  assign rd_req = !bus.csb1 && open_q;

  logic                  port_we;
  logic [NUM_WMASKS-1:0] port_mask;
  logic [ADDR_WIDTH-1:0] port_addr;
  logic [DATA_WIDTH-1:0] port_din;

  always_comb begin
    port_we   = 1'b0;
    port_mask = '0;
    port_addr = bus.addr0;
    port_din  = bus.din0;
    if (clr_we) begin
      port_we   = 1'b1;
      port_mask = '1;
      port_addr = clr_addr;
      port_din  = '0;
    end else if (wr_req) begin
      port_we   = |bus.wmask0;
      port_mask = bus.wmask0;
    end
  end

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (port_we) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (port_mask[i]) begin
          mem[port_addr][8*i +: 8] <= port_din[8*i +: 8];
        end
      end
    end
  end

  // Read word as seen at the sampling edge, with same-address write merged in
  // lane by lane when the new-data policy is selected.
  logic [DATA_WIDTH-1:0] rd_word;
  always_comb begin
    rd_word = mem[bus.addr1];
    if (RDW_MODE == RDW_NEW && wr_req && bus.addr0 == bus.addr1) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (bus.wmask0[i]) begin
          rd_word[8*i +: 8] = bus.din0[8*i +: 8];
        end
      end
    end
  end

  logic                  s0_v;
  logic [DATA_WIDTH-1:0] s0_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_v    <= 1'b0;
      s0_data <= '0;
    end else begin
      s0_v <= rd_req;
      if (rd_req) begin
        s0_data <= rd_word;
      end
    end
  end

  logic                  out_v;
  logic [DATA_WIDTH-1:0] out_data;

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s1_v;
    logic [DATA_WIDTH-1:0] s1_data;
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_v     <= 1'b0;
        s1_data  <= '0;
        out_v    <= 1'b0;
        out_data <= '0;
      end else begin
        s1_v  <= s0_v;
        out_v <= s1_v;
        if (s0_v) begin
          s1_data <= s0_data;
        end
        if (s1_v) begin
          out_data <= s1_data;
        end
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk) begin
      if (rst) begin
        out_v    <= 1'b0;
        out_data <= '0;
      end else begin
        out_v <= s0_v;
        if (s0_v) begin
          out_data <= s0_data;
        end
      end
    end
  end

  assign bus.dout1       = out_data;
  assign bus.dout1_valid = out_v;
  assign bus.busy        = busy;
  assign dbg_state       = clr_state;
  assign dbg_clr_addr    = clr_addr;

endmodule

// File: tb/tb_sram_1w1r_param.sv
// Bench for sram_1w1r_param: two instances (latency 1 / old-data, latency 2 /
// new-data) driven in lockstep, each with its own expected-read queue.
module tb_sram_1w1r_param;
  import sram_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int NW    = 4;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          csb0   = 1'b1;
  logic [NW-1:0] wmask0 = '0;
  logic [AW-1:0] addr0  = '0;
  logic [DW-1:0] din0   = '0;
  logic          csb1   = 1'b1;
  logic [AW-1:0] addr1  = '0;

  sram_1w1r_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_a ();
  sram_1w1r_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_b ();

  assign if_a.csb0 = csb0;  assign if_b.csb0 = csb0;
  assign if_a.wmask0 = wmask0;  assign if_b.wmask0 = wmask0;
  assign if_a.addr0 = addr0;  assign if_b.addr0 = addr0;
  assign if_a.din0 = din0;  assign if_b.din0 = din0;
  assign if_a.csb1 = csb1;  assign if_b.csb1 = csb1;
  assign if_a.addr1 = addr1;  assign if_b.addr1 = addr1;

  sram_clr_state_t st_a, st_b;
  logic [AW-1:0]   ca_a, ca_b;

  sram_1w1r_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1),
    .RDW_MODE(RDW_OLD), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(if_a), .dbg_state(st_a), .dbg_clr_addr(ca_a)
  );

  sram_1w1r_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2),
    .RDW_MODE(RDW_NEW), .CLEAR_ON_RESET(1)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(if_b), .dbg_state(st_b), .dbg_clr_addr(ca_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q_a[$];
  logic [DW-1:0] exp_q_b[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (if_a.dout1_valid === 1'b1) begin
      if (exp_q_a.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb_a_unexpected actual=valid(dout1=%h) required=no pulse @%0t", if_a.dout1, $time);
      end else begin
        check("sb_a_data", if_a.dout1, exp_q_a.pop_front());
      end
    end
    if (if_b.dout1_valid === 1'b1) begin
      if (exp_q_b.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb_b_unexpected actual=valid(dout1=%h) required=no pulse @%0t", if_b.dout1, $time);
      end else begin
        check("sb_b_data", if_b.dout1, exp_q_b.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csb0 = 1'b1; csb1 = 1'b1; wmask0 = '0;
  endtask

  task automatic drive_read(input logic [AW-1:0] a, input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    csb1 = 1'b0; addr1 = a;
    exp_q_a.push_back(ea);
    exp_q_b.push_back(eb);
  endtask

  task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NW-1:0] m);
    csb0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((if_a.busy !== 1'b0 || if_b.busy !== 1'b0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle_timeout actual=busy_a:%b busy_b:%b required=0 after %0d cycles", if_a.busy, if_b.busy, budget);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          wr;
    logic [NW-1:0] mask;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          rd;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [6:0] va;
    logic [6:0] vb;
    int n;

    vecs[0]  = '{1'b1, 4'hF, 4'd5,  32'hAABBCCDD, 1'b0, 4'd0,  32'h0,        32'h0};
    vecs[1]  = '{1'b1, 4'h5, 4'd5,  32'h11223344, 1'b0, 4'd0,  32'h0,        32'h0};
    vecs[2]  = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 4'd5,  32'hAA22CC44, 32'hAA22CC44};
    vecs[3]  = '{1'b1, 4'hF, 4'd7,  32'h12345678, 1'b0, 4'd0,  32'h0,        32'h0};
    vecs[4]  = '{1'b1, 4'h3, 4'd7,  32'hFFFFFFFF, 1'b1, 4'd7,  32'h12345678, 32'h1234FFFF};
    vecs[5]  = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 4'd7,  32'h1234FFFF, 32'h1234FFFF};
    vecs[6]  = '{1'b1, 4'hF, 4'd3,  32'hCAFEF00D, 1'b1, 4'd5,  32'hAA22CC44, 32'hAA22CC44};
    vecs[7]  = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 4'd3,  32'hCAFEF00D, 32'hCAFEF00D};
    vecs[8]  = '{1'b1, 4'h0, 4'd0,  32'hFFFFFFFF, 1'b1, 4'd0,  32'h0,        32'h0};
    vecs[9]  = '{1'b1, 4'h8, 4'd9,  32'h01020304, 1'b1, 4'd9,  32'h0,        32'h01000000};
    vecs[10] = '{1'b1, 4'hF, 4'd15, 32'h55AA55AA, 1'b1, 4'd9,  32'h01000000, 32'h01000000};
    vecs[11] = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 4'd15, 32'h55AA55AA, 32'h55AA55AA};

    // ---- reset values ----
    idle();
    rst = 1'b1;
    step();
    check("rst_dout_a", if_a.dout1, '0);
    check("rst_dout_b", if_b.dout1, '0);
    check("rst_valid_a", {31'b0, if_a.dout1_valid}, '0);
    check("rst_valid_b", {31'b0, if_b.dout1_valid}, '0);
    check("rst_busy_a", {31'b0, if_a.busy}, 32'd1);
    check("rst_busy_b", {31'b0, if_b.busy}, 32'd1);
    check("rst_state_a", {31'b0, st_a}, {31'b0, S_CLEAR});
    check("rst_clr_addr_a", {28'b0, ca_a}, '0);
    step();
    step();
    rst = 1'b0;

    // ---- clear sweep, with a dropped write and read mid-sweep ----
    for (int e = 1; e <= DEPTH; e++) begin
      step();
      check("sweep_busy_a", {31'b0, if_a.busy}, 32'd1);
      check("sweep_busy_b", {31'b0, if_b.busy}, 32'd1);
      if (e == 6) begin
        drive_write(4'd2, 32'hDEADBEEF, 4'hF);
        csb1 = 1'b0; addr1 = 4'd2;
      end else begin
        idle();
      end
      if (e == 9)  check("sweep_addr9", {28'b0, ca_b}, 32'd9);
      if (e == 15) check("sweep_state15", {31'b0, st_a}, {31'b0, S_CLEAR});
      if (e == 16) check("sweep_state16", {31'b0, st_b}, {31'b0, S_IDLE});
    end
    step();
    check("sweep_done_busy_a", {31'b0, if_a.busy}, '0);
    check("sweep_done_busy_b", {31'b0, if_b.busy}, '0);

    for (int a = 0; a < DEPTH; a++) begin
      drive_read(AW'(a), '0, '0);
      step();
    end
    idle();
    repeat (4) step();

    // ---- table-driven vectors ----
    for (int i = 0; i < 12; i++) begin
      csb0 = !vecs[i].wr; wmask0 = vecs[i].mask; addr0 = vecs[i].wa; din0 = vecs[i].wd;
      if (vecs[i].rd) drive_read(vecs[i].ra, vecs[i].exp_a, vecs[i].exp_b);
      else csb1 = 1'b1;
      step();
    end
    idle();
    repeat (4) step();

    // ---- latency and throughput ----
    for (int a = 0; a < 4; a++) begin
      drive_write(AW'(a), 32'hA0000000 + a, 4'hF);
      step();
    end
    idle();
    step();
    drive_read(4'd0, 32'hA0000000, 32'hA0000000);
    for (int k = 0; k < 7; k++) begin
      step();
      va[k] = if_a.dout1_valid;
      vb[k] = if_b.dout1_valid;
      if (k < 3) drive_read(AW'(k + 1), 32'hA0000001 + k, 32'hA0000001 + k);
      else idle();
    end
    check("lat1_valid_pattern", {25'b0, va}, {25'b0, 7'b0011110});
    check("lat2_valid_pattern", {25'b0, vb}, {25'b0, 7'b0111100});
    step();
    check("hold_dout_a", if_a.dout1, 32'hA0000003);
    check("hold_dout_b", if_b.dout1, 32'hA0000003);

    // ---- reset mid-operation: in-flight read squashed, pending write lost ----
    csb1 = 1'b0; addr1 = 4'd5;
    step();
    rst = 1'b1;
    drive_write(4'd4, 32'h77777777, 4'hF);
    addr1 = 4'd6;
    step();
    check("midrst_valid_a", {31'b0, if_a.dout1_valid}, '0);
    check("midrst_valid_b", {31'b0, if_b.dout1_valid}, '0);
    check("midrst_dout_a", if_a.dout1, '0);
    check("midrst_dout_b", if_b.dout1, '0);
    check("midrst_busy_a", {31'b0, if_a.busy}, 32'd1);
    step();
    step();
    rst = 1'b0;
    idle();
    n = 0;
    while (ca_a !== 4'd9 && n < 40) begin
      step();
      n++;
    end
    check("reach_addr9", {28'b0, ca_a}, 32'd9);
    rst = 1'b1;
    drive_write(4'd9, 32'h99999999, 4'hF);
    step();
    check("restart_addr_a", {28'b0, ca_a}, '0);
    check("restart_addr_b", {28'b0, ca_b}, '0);
    check("restart_state_a", {31'b0, st_a}, {31'b0, S_CLEAR});
    step();
    rst = 1'b0;
    idle();
    wait_idle(40);
    drive_read(4'd4, '0, '0);
    step();
    drive_read(4'd9, '0, '0);
    step();
    drive_read(4'd5, '0, '0);
    step();
    idle();
    repeat (5) step();

    check("queue_a_empty", DW'(exp_q_a.size()), '0);
    check("queue_b_empty", DW'(exp_q_b.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog actual=still running required=finished by 200000");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
